// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl
//   Initiator side of the CSR register-file port, sitting in the MW stage. It
//   turns each request into a sequence of single-address read or write cycles:
//   a Zicsr read-modify-write op, M-mode external-interrupt entry, or mret
//   return. The register file answers reads combinationally from csr_inaddr
//   and commits writes on the clock edge when csr_reg_wrMW is high.
//
//   Requests accepted in IDLE, one per cycle, priority irq > mret > op.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   op_valid/op_ready       CSR instruction handshake
//   op_funct3/op_addr       Zicsr op kind and CSR address
//   op_src/op_src_zero      operand (rs1 or zimm) and its "field is zero" flag
//   op_done/op_rd_data      1-cycle completion pulse with the old CSR value
//   irq_req/trap_pc         level external interrupt, PC saved into mepc
//   irq_ack                 1-cycle pulse when the trap is taken
//   mret_req                mret in MW, held until redirect_valid
//   redirect_valid/_pc      1-cycle fetch redirect and its target
//   csr_inaddr/csr_wdata    register-file address and write data
//   csr_reg_rdMW/_wrMW      register-file read and write strobes
//   csr_rdata               combinational register-file read data
//
// Configuration
//   CSR_VECTORED_EN  when defined, mtvec mode 01 vectors the external
//                    interrupt to base + 4*IRQ_CODE; otherwise the mode bits
//                    are ignored and the target is always the base.

module csr_access_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IRQ_CODE = 11,
    parameter int unsigned MEIE_BIT = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_funct3,
    input  logic [11:0]     op_addr,
    input  logic [XLEN-1:0] op_src,
    input  logic            op_src_zero,
    output logic            op_done,
    output logic [XLEN-1:0] op_rd_data,
    input  logic            irq_req,
    input  logic [XLEN-1:0] trap_pc,
    output logic            irq_ack,
    input  logic            mret_req,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] csr_inaddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_reg_rdMW,
    output logic            csr_reg_wrMW,
    input  logic [XLEN-1:0] csr_rdata
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OP_RD,
        S_OP_WR,
        S_CHK_MS,
        S_CHK_IE,
        S_WR_EPC,
        S_WR_CAUSE,
        S_WR_MS,
        S_RD_VEC,
        S_MR_EPC,
        S_MR_MS,
        S_MR_WR
    } state_t;

    state_t          state;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ms_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] rdpc_q;
    logic [1:0]      f3_q;
    logic            zero_q;
    logic            rd_q;
    logic            wr_q;
    logic            done_q;
    logic            ack_q;
    logic            rdir_q;
    logic            skip_irq;   // last IDLE exit was a failed enable check

    logic            irq_elig;
    logic            op_wr_en;
    logic [XLEN-1:0] op_new;
    logic [XLEN-1:0] ms_trap;
    logic [XLEN-1:0] ms_mret;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_target;
    logic [XLEN-1:0] epc_aligned;
    logic [XLEN-1:0] cause_val;

    // funct3[2] only selects rs1 vs zimm, already resolved into op_src;
    // mepc is always word aligned, so the low trap_pc bits are dropped.
    logic            unused_bits;
    assign unused_bits = &{1'b0, op_funct3[2], pc_q[1:0]};

    function automatic logic [XLEN-1:0] zext12(input logic [11:0] a);
        return {{(XLEN-12){1'b0}}, a};
    endfunction

    always_comb begin
        irq_elig    = irq_req & ~skip_irq;
        op_wr_en    = ~(f3_q[1] & zero_q);

        // csr_rdata holds the old value of op_addr while in S_OP_RD
        case (f3_q)
            2'b10:   op_new = csr_rdata | src_q;
            2'b11:   op_new = csr_rdata & ~src_q;
            default: op_new = src_q;
        endcase

        ms_trap     = ms_q;
        ms_trap[7]  = ms_q[3];
        ms_trap[3]  = 1'b0;

        ms_mret     = csr_rdata;
        ms_mret[3]  = csr_rdata[7];
        ms_mret[7]  = 1'b1;

        epc_aligned = {pc_q[XLEN-1:2], 2'b00};
        cause_val   = {1'b1, (XLEN-1)'(IRQ_CODE)};

        vec_base    = {csr_rdata[XLEN-1:2], 2'b00};
        vec_target  = vec_base;
`ifdef CSR_VECTORED_EN
        if (csr_rdata[1:0] == 2'b01)
            vec_target = vec_base + XLEN'(4 * IRQ_CODE);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            src_q     <= '0;
            pc_q      <= '0;
            ms_q      <= '0;
            epc_q     <= '0;
            rdpc_q    <= '0;
            f3_q      <= '0;
            zero_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            rdir_q    <= 1'b0;
            skip_irq  <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            ack_q  <= 1'b0;
            rdir_q <= 1'b0;

            // Strobes and addresses are registered for the state being entered,
            // so each case sets up the bus cycle of its successor.
            case (state)
                S_IDLE: begin
                    if (irq_elig) begin
                        state    <= S_CHK_MS;
                        pc_q     <= trap_pc;
                        addr_q   <= zext12(A_MSTATUS);
                        rd_q     <= 1'b1;
                        skip_irq <= 1'b0;
                    end else if (mret_req) begin
                        state    <= S_MR_EPC;
                        addr_q   <= zext12(A_MEPC);
                        rd_q     <= 1'b1;
                        skip_irq <= 1'b0;
                    end else if (op_valid) begin
                        state    <= S_OP_RD;
                        f3_q     <= op_funct3[1:0];
                        src_q    <= op_src;
                        zero_q   <= op_src_zero;
                        addr_q   <= zext12(op_addr);
                        rd_q     <= 1'b1;
                        skip_irq <= 1'b0;
                    end
                end

                S_OP_RD: begin
                    state     <= S_OP_WR;
                    rd_data_q <= csr_rdata;
                    wdata_q   <= op_new;
                    // a suppressed write still keeps the bus busy with a read
                    wr_q      <= op_wr_en;
                    rd_q      <= ~op_wr_en;
                    done_q    <= 1'b1;
                end

                S_OP_WR: state <= S_IDLE;

                S_CHK_MS: begin
                    state  <= S_CHK_IE;
                    ms_q   <= csr_rdata;
                    addr_q <= zext12(A_MIE);
                    rd_q   <= 1'b1;
                end

                S_CHK_IE: begin
                    if (ms_q[3] & csr_rdata[MEIE_BIT]) begin
                        state   <= S_WR_EPC;
                        addr_q  <= zext12(A_MEPC);
                        wdata_q <= epc_aligned;
                        wr_q    <= 1'b1;
                    end else begin
                        state    <= S_IDLE;
                        skip_irq <= 1'b1;
                    end
                end

                S_WR_EPC: begin
                    state   <= S_WR_CAUSE;
                    addr_q  <= zext12(A_MCAUSE);
                    wdata_q <= cause_val;
                    wr_q    <= 1'b1;
                end

                S_WR_CAUSE: begin
                    state   <= S_WR_MS;
                    addr_q  <= zext12(A_MSTATUS);
                    wdata_q <= ms_trap;
                    wr_q    <= 1'b1;
                end

                S_WR_MS: begin
                    state  <= S_RD_VEC;
                    addr_q <= zext12(A_MTVEC);
                    rd_q   <= 1'b1;
                    ack_q  <= 1'b1;
                    rdir_q <= 1'b1;
                end

                S_RD_VEC: state <= S_IDLE;

                S_MR_EPC: begin
                    state  <= S_MR_MS;
                    epc_q  <= csr_rdata;
                    addr_q <= zext12(A_MSTATUS);
                    rd_q   <= 1'b1;
                end

                S_MR_MS: begin
                    state   <= S_MR_WR;
                    ms_q    <= csr_rdata;
                    wdata_q <= ms_mret;
                    wr_q    <= 1'b1;
                    rdir_q  <= 1'b1;
                    rdpc_q  <= epc_q;
                end

                S_MR_WR: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

    assign op_ready       = (state == S_IDLE) & ~reset & ~irq_elig & ~mret_req;
    assign csr_inaddr     = addr_q;
    assign csr_wdata      = wdata_q;
    // reset kills the strobe of the cycle it arrives in, not just the next one
    assign csr_reg_rdMW   = rd_q & ~reset;
    assign csr_reg_wrMW   = wr_q & ~reset;
    assign op_done        = done_q & ~reset;
    assign op_rd_data     = rd_data_q;
    assign irq_ack        = ack_q & ~reset;
    assign redirect_valid = rdir_q & ~reset;
    // the vector target depends on mtvec read in the same cycle
    assign redirect_pc    = (state == S_RD_VEC) ? vec_target : rdpc_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_funct3;
    logic [11:0] op_addr;
    logic [31:0] op_src;
    logic        op_src_zero;
    logic        op_done;
    logic [31:0] op_rd_data;
    logic        irq_req;
    logic [31:0] trap_pc;
    logic        irq_ack;
    logic        mret_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] csr_inaddr;
    logic [31:0] csr_wdata;
    logic        csr_reg_rdMW;
    logic        csr_reg_wrMW;
    logic [31:0] csr_rdata;

    csr_access_ctrl #(.XLEN(32), .IRQ_CODE(11), .MEIE_BIT(11)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_funct3(op_funct3),
        .op_addr(op_addr), .op_src(op_src), .op_src_zero(op_src_zero),
        .op_done(op_done), .op_rd_data(op_rd_data),
        .irq_req(irq_req), .trap_pc(trap_pc), .irq_ack(irq_ack),
        .mret_req(mret_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_inaddr(csr_inaddr), .csr_wdata(csr_wdata),
        .csr_reg_rdMW(csr_reg_rdMW), .csr_reg_wrMW(csr_reg_wrMW), .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Register file environment: combinational read, write on the edge.
    logic [31:0] file [0:4095];
    logic        clr = 1'b0;
    logic        pre_en = 1'b0;
    logic [11:0] pre_a = '0;
    logic [31:0] pre_d = '0;

    assign csr_rdata = file[csr_inaddr[11:0]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) file[i] <= '0;
        end else if (pre_en) begin
            file[pre_a] <= pre_d;
        end else if (csr_reg_wrMW) begin
            file[csr_inaddr[11:0]] <= csr_wdata;
        end
    end

    // Reference model state
    logic [31:0] mref [0:4095];
    bit          lastfail = 1'b0;

    typedef struct {
        int          cyc;
        int          kind;   // 0 write, 1 done, 2 redirect/ack
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    ev_t expq[$];

    string kn [3] = '{"wr", "done", "redirect"};

    task automatic push(input int c, input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.cyc = c; e.kind = k; e.a = a; e.d = d;
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %h required %h", nm, cyc, act, req);
        end
    endtask

    task automatic got(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s at cyc %0d: got a=%h d=%h required no event", kn[k], cyc, a, d);
        end else begin
            e = expq.pop_front();
            if (e.cyc != cyc || e.kind != k || e.a !== a || e.d !== d) begin
                failures++;
                $display("FAIL event_%s: got cyc=%0d kind=%0d a=%h d=%h required cyc=%0d kind=%0d a=%h d=%h",
                         kn[k], cyc, k, a, d, e.cyc, e.kind, e.a, e.d);
            end
        end
    endtask

    // Monitor: every observable bus write, done pulse and redirect is matched
    // against the scoreboard in order.
    always @(negedge clk) begin
        checks++;
        if (csr_reg_rdMW && csr_reg_wrMW) begin
            failures++;
            $display("FAIL strobe_onehot at cyc %0d: got rd=1 wr=1 required at most one", cyc);
        end
        if (csr_reg_wrMW) got(0, csr_inaddr, csr_wdata);
        if (op_done) got(1, 32'd0, op_rd_data);
        if (redirect_valid || irq_ack) got(2, {30'd0, redirect_valid, irq_ack}, redirect_pc);
    end

    function automatic logic [31:0] vec_target(input logic [31:0] mtvec);
        logic [31:0] base;
        base = mtvec & ~32'd3;
`ifdef CSR_VECTORED_EN
        if (mtvec[1:0] == 2'b01) return base + 32'd44;
`endif
        return base;
    endfunction

    task automatic setreg(input logic [11:0] a, input logic [31:0] d);
        irq_req = 1'b0; mret_req = 1'b0; op_valid = 1'b0;
        pre_en = 1'b1; pre_a = a; pre_d = d;
        mref[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // One arbitration slot, entered on the negedge of an idle cycle. The model
    // decides which request wins and what the register file must see.
    task automatic slot(input bit irq, input bit mr, input bit ov, input logic [2:0] f3,
                        input logic [11:0] a, input logic [31:0] src, input bit z,
                        input logic [31:0] pc);
        int          c;
        int          n;
        bit          elig;
        logic [31:0] old, nv, ms, ie, epc;
        irq_req = irq; mret_req = mr; op_valid = ov; op_funct3 = f3;
        op_addr = a; op_src = src; op_src_zero = z; trap_pc = pc;
        c    = cyc;
        elig = irq && !lastfail;
        #1;
        chk("op_ready_idle", {31'd0, op_ready}, {31'd0, !elig && !mr});
        n = 1;
        if (elig) begin
            lastfail = 1'b0;
            ms = mref[12'h300];
            ie = mref[12'h304];
            if (ms[3] && ie[11]) begin
                push(c + 3, 0, 32'h341, pc & ~32'd3);
                mref[12'h341] = pc & ~32'd3;
                push(c + 4, 0, 32'h342, 32'h8000_000B);
                mref[12'h342] = 32'h8000_000B;
                nv = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
                push(c + 5, 0, 32'h300, nv);
                mref[12'h300] = nv;
                push(c + 6, 2, 32'd3, vec_target(mref[12'h305]));
                n = 7;
            end else begin
                lastfail = 1'b1;
                n = 3;
            end
        end else if (mr) begin
            lastfail = 1'b0;
            epc = mref[12'h341];
            ms  = mref[12'h300];
            nv  = (ms & ~32'h8) | (ms[7] ? 32'h8 : 32'h0) | 32'h80;
            push(c + 3, 0, 32'h300, nv);
            push(c + 3, 2, 32'd2, epc);
            mref[12'h300] = nv;
            n = 4;
        end else if (ov) begin
            lastfail = 1'b0;
            old = mref[a];
            case (f3[1:0])
                2'b10:   nv = old | src;
                2'b11:   nv = old & ~src;
                default: nv = src;
            endcase
            if (!(f3[1] && z)) begin
                push(c + 2, 0, {20'd0, a}, nv);
                mref[a] = nv;
            end
            push(c + 2, 1, 32'd0, old);
            n = 3;
        end
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            // requests outside IDLE must be ignored, and irq may drop mid-trap
            irq_req  = 1'($urandom_range(0, 1));
            mret_req = 1'($urandom_range(0, 1));
            op_valid = 1'($urandom_range(0, 1));
            op_addr  = 12'($urandom);
            op_src   = $urandom;
            trap_pc  = $urandom;
            #1;
            chk("op_ready_busy", {31'd0, op_ready}, 32'd0);
        end
        @(negedge clk);
    endtask

    logic [2:0]  f3tab [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [11:0] atab  [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h340};

    initial begin
        int          c;
        bit          ri, rm, rv, rz;
        logic [2:0]  rf;
        logic [11:0] ra;
        logic [31:0] rs, rp;

        for (int i = 0; i < 4096; i++) mref[i] = '0;
        reset = 1'b1; clr = 1'b1;
        op_valid = 1'b0; op_funct3 = '0; op_addr = '0; op_src = '0; op_src_zero = 1'b0;
        irq_req = 1'b0; trap_pc = '0; mret_req = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_done", {31'd0, op_done}, 32'd0);
        chk("rst_ack", {31'd0, irq_ack}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_rd", {31'd0, csr_reg_rdMW}, 32'd0);
        chk("rst_wr", {31'd0, csr_reg_wrMW}, 32'd0);
        chk("rst_rd_data", op_rd_data, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_wdata", csr_wdata, 32'd0);
        chk("rst_inaddr", csr_inaddr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // CSRRW into a zero mtvec
        slot(0, 0, 1, 3'b001, 12'h305, 32'h100, 0, 0);
        // set / clear / set-with-zero-source on mstatus
        setreg(12'h300, 32'h80);
        slot(0, 0, 1, 3'b010, 12'h300, 32'h8, 0, 0);
        slot(0, 0, 1, 3'b011, 12'h300, 32'h80, 0, 0);
        slot(0, 0, 1, 3'b010, 12'h300, 32'h0, 1, 0);
        // enabled trap entry
        setreg(12'h300, 32'h8);
        setreg(12'h304, 32'h800);
        setreg(12'h305, 32'h200);
        slot(1, 0, 0, 3'b001, 12'h000, 0, 0, 32'h44);
        // disabled trap: no writes, concurrent op waits one IDLE exit
        setreg(12'h300, 32'h0);
        slot(1, 0, 1, 3'b110, 12'h342, 32'h0, 1, 32'h50);
        slot(1, 0, 1, 3'b110, 12'h342, 32'h0, 1, 32'h50);
        // mret
        setreg(12'h341, 32'h44);
        setreg(12'h300, 32'h80);
        slot(0, 1, 0, 3'b001, 12'h000, 0, 0, 0);
        // irq and mret together: trap first, then mret
        setreg(12'h300, 32'h8);
        slot(1, 1, 1, 3'b001, 12'h300, 32'h1, 0, 32'h123);
        slot(0, 1, 1, 3'b001, 12'h300, 32'h1, 0, 0);
        // vectored mtvec
        setreg(12'h300, 32'h8);
        setreg(12'h305, 32'h201);
        slot(1, 0, 0, 3'b001, 12'h000, 0, 0, 32'h88);

        // reset during trap WR_CAUSE: mepc written, nothing after
        setreg(12'h300, 32'h8);
        irq_req = 1'b1; trap_pc = 32'h0000_0A0E;
        c = cyc;
        push(c + 3, 0, 32'h341, 32'h0000_0A0C);
        mref[12'h341] = 32'h0000_0A0C;
        repeat (3) begin
            @(negedge clk);
            irq_req = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        lastfail = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, op_ready}, 32'd1);
        chk("post_reset_cyc", cyc, c + 5);
        slot(0, 0, 1, 3'b010, 12'h342, 32'h0, 1, 0);
        slot(0, 0, 1, 3'b010, 12'h300, 32'h0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0:       setreg(12'h300, $urandom);
                    1:       setreg(12'h304, $urandom);
                    2:       setreg(12'h305, $urandom);
                    default: setreg(12'h341, $urandom);
                endcase
            end
            ri = ($urandom_range(0, 3) == 0);
            rm = ($urandom_range(0, 4) == 0);
            rv = ($urandom_range(0, 9) < 7);
            rf = f3tab[$urandom_range(0, 5)];
            ra = ($urandom_range(0, 6) == 6) ? 12'($urandom) : atab[$urandom_range(0, 5)];
            rz = ($urandom_range(0, 3) == 0);
            rs = rz ? 32'd0 : $urandom;
            rp = $urandom;
            slot(ri, rm, rv, rf, ra, rs, rz, rp);
        end

        irq_req = 1'b0; mret_req = 1'b0; op_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
